wb_stage_pipe: RTL

Parametrised, registered successor to the combinational writeback stage. It holds the MEM/WB pipeline register with stall and flush, and extracts load data from synchronous data-memory read data. Load extraction covers byte, halfword and word, with a sign/zero-extension choice and optional byte-lane swapping. It drives register-file and HI/LO write ports, and flags illegal byte-enable patterns.

---
 rtl/wb_stage_pipe_pkg.sv | 39 +++
 rtl/wb_stage_pipe_if.sv | 47 ++++
 rtl/wb_stage_pipe_load_align.sv | 53 +++++
 rtl/wb_stage_pipe.sv | 103 ++++++++++
 4 files changed

// File: rtl/wb_stage_pipe_pkg.sv
// Shared types, constants and helpers for the registered writeback stage.
package wb_stage_pipe_pkg;

  // Default configuration: a 32-bit datapath.
  localparam int DATA_W_DEF = 32;
  localparam int NB         = DATA_W_DEF / 8;
  localparam int HILO_W     = 2 * DATA_W_DEF;

  // Largest lane count the helpers handle. This covers DATA_W up to 256.
  localparam int MAX_NB = 32;

  // Full-width lane masks. Users slice them down to their own lane count.
  localparam logic [MAX_NB-1:0] DRE_WORD = '1;
  localparam logic [MAX_NB-1:0] DRE_NONE = '0;

  // Result of classifying a lane-enable pattern as an aligned halfword.
  typedef struct packed {
    logic       legal;
    logic [7:0] idx;
  } half_sel_t;

  // Returns legal=1 and the halfword index j when dre is exactly {2j+1,2j}.
  function automatic half_sel_t is_half(input logic [MAX_NB-1:0] dre, input int nb);
    half_sel_t         r;
    logic [MAX_NB-1:0] m;
    r = '0;
    for (int j = 0; j < MAX_NB / 2; j++) begin
      m          = '0;
      m[2*j]     = 1'b1;
      m[2*j + 1] = 1'b1;
      if ((2 * j + 1 < nb) && (dre == m)) begin
        r.legal = 1'b1;
        r.idx   = 8'(j);
      end
    end
    return r;
  endfunction

endpackage

// File: rtl/wb_stage_pipe_if.sv
// MEM->WB bus of the writeback stage. It also carries the RAM read data,
// the stall/flush controls and the register-file/HI-LO write ports.
//
// Handshake semantics: there is no valid/ready pair. The enables act as
// valids (mem_wreg_i, mem_whilo_i in, wb_wreg_o, wb_whilo_o out). stall_i is
// the only back-pressure: while it is high, the WB register and any captured
// load data are held. flush_i turns the next WB slot into a bubble and wins
// over stall_i.
interface wb_stage_pipe_if #(
  parameter int DATA_W = 32,
  parameter int REG_AW = 5
);
  localparam int LANES = DATA_W / 8;

  logic [REG_AW-1:0]   mem_wa_i;
  logic                mem_wreg_i;
  logic [DATA_W-1:0]   mem_dreg_i;
  logic                mem_mreg_i;
  logic [LANES-1:0]    mem_dre_i;
  logic                mem_sext_i;
  logic                mem_whilo_i;
  logic [2*DATA_W-1:0] mem_hilo_i;
  logic [DATA_W-1:0]   dm_i;
  logic                stall_i;
  logic                flush_i;

  logic [REG_AW-1:0]   wb_wa_o;
  logic                wb_wreg_o;
  logic [DATA_W-1:0]   wb_wd_o;
  logic                wb_whilo_o;
  logic [2*DATA_W-1:0] wb_hilo_o;
  logic                wb_lderr_o;

  // Pipeline side: drives the MEM outputs, RAM data and controls.
  modport master (
    output mem_wa_i, mem_wreg_i, mem_dreg_i, mem_mreg_i, mem_dre_i,
           mem_sext_i, mem_whilo_i, mem_hilo_i, dm_i, stall_i, flush_i,
    input  wb_wa_o, wb_wreg_o, wb_wd_o, wb_whilo_o, wb_hilo_o, wb_lderr_o
  );

  // Writeback stage side.
  modport slave (
    input  mem_wa_i, mem_wreg_i, mem_dreg_i, mem_mreg_i, mem_dre_i,
           mem_sext_i, mem_whilo_i, mem_hilo_i, dm_i, stall_i, flush_i,
    output wb_wa_o, wb_wreg_o, wb_wd_o, wb_whilo_o, wb_hilo_o, wb_lderr_o
  );
endinterface

// File: rtl/wb_stage_pipe_load_align.sv
// Combinational load extractor. It picks a byte, an aligned halfword or the
// full word out of a source word based on the lane enables, optionally
// reverses byte order, and sign- or zero-extends the result. Any lane pattern
// that is none of those shapes is reported as an error and yields zero.
module wb_load_align
  import wb_stage_pipe_pkg::*;
#(
  parameter int DATA_W    = 32,
  parameter bit BYTE_SWAP = 1'b1
) (
  input  logic [DATA_W-1:0]   src,
  input  logic [DATA_W/8-1:0] dre,
  input  logic                sext,
  output logic [DATA_W-1:0]   data,
  output logic                err
);
  localparam int LANES = DATA_W / 8;

  half_sel_t         hs;
  logic [DATA_W-1:0] swapped;
  logic [7:0]        b;
  logic [15:0]       h;

  // Decode the lane pattern and extract, extend or flag the load.
  always_comb begin
    data    = '0;
    err     = 1'b0;
    b       = '0;
    h       = '0;
    swapped = '0;
    hs      = is_half(MAX_NB'(dre), LANES);
    for (int i = 0; i < LANES; i++) begin
      swapped[8*i +: 8] = src[8*(LANES-1-i) +: 8];
    end
    if (dre == DRE_WORD[LANES-1:0]) begin
      data = BYTE_SWAP ? swapped : src;
    end else if ($onehot(dre)) begin
      for (int k = 0; k < LANES; k++) begin
        if (dre[k]) b = src[8*k +: 8];
      end
      data = {{(DATA_W-8){sext & b[7]}}, b};
    end else if (hs.legal) begin
      for (int j = 0; j < LANES / 2; j++) begin
        if (hs.idx == 8'(j)) h = src[16*j +: 16];
      end
      if (BYTE_SWAP) h = {h[7:0], h[15:8]};
      data = {{(DATA_W-16){sext & h[15]}}, h};
    end else begin
      err = 1'b1;
    end
  end

endmodule

// File: rtl/wb_stage_pipe.sv
// Registered writeback stage. It holds the MEM/WB pipeline register with
// flush and stall, and extracts load data from synchronous RAM read data.
// While a load is stalled in WB, the RAM word is frozen in a hold register
// so the write data stays stable even if the RAM output moves.
module wb_stage_pipe
  import wb_stage_pipe_pkg::*;
#(
  parameter int DATA_W    = 32,
  parameter int REG_AW    = 5,
  parameter bit BYTE_SWAP = 1'b1
) (
  input logic              cpu_clk_50M,
  input logic              cpu_rst,
  wb_stage_pipe_if.slave   bus
);
  localparam int LANES = DATA_W / 8;

  logic [REG_AW-1:0]   r_wa;
  logic                r_wreg;
  logic [DATA_W-1:0]   r_dreg;
  logic                r_mreg;
  logic [LANES-1:0]    r_dre;
  logic                r_sext;
  logic                r_whilo;
  logic [2*DATA_W-1:0] r_hilo;
  logic                hold;
  logic [DATA_W-1:0]   hold_q;

  logic [DATA_W-1:0]   src;
  logic [DATA_W-1:0]   ld_data;
  logic                ld_err;
  logic                lderr;
  logic                wreg;

  // MEM/WB register with priority reset > flush > stall > capture.
  // On a stall it freezes the RAM word for a load that sits in WB.
  always_ff @(posedge cpu_clk_50M or posedge cpu_rst) begin
    if (cpu_rst) begin
      r_wa    <= '0;
      r_wreg  <= 1'b0;
      r_dreg  <= '0;
      r_mreg  <= 1'b0;
      r_dre   <= DRE_NONE[LANES-1:0];
      r_sext  <= 1'b0;
      r_whilo <= 1'b0;
      r_hilo  <= '0;
      hold    <= 1'b0;
      hold_q  <= '0;
    end else if (bus.flush_i) begin
      r_wreg  <= 1'b0;
      r_whilo <= 1'b0;
      r_mreg  <= 1'b0;
      r_dre   <= DRE_NONE[LANES-1:0];
      hold    <= 1'b0;
    end else if (bus.stall_i) begin
      if (r_mreg && !hold) begin
        hold_q <= bus.dm_i;
        hold   <= 1'b1;
      end
    end else begin
      r_wa    <= bus.mem_wa_i;
      r_wreg  <= bus.mem_wreg_i;
      r_dreg  <= bus.mem_dreg_i;
      r_mreg  <= bus.mem_mreg_i;
      r_dre   <= bus.mem_dre_i;
      r_sext  <= bus.mem_sext_i;
      r_whilo <= bus.mem_whilo_i;
      r_hilo  <= bus.mem_hilo_i;
      hold    <= 1'b0;
    end
  end

  // Use the frozen word while holding, otherwise the live RAM output.
  always_comb begin
    src = hold ? hold_q : bus.dm_i;
  end

  wb_load_align #(
    .DATA_W    (DATA_W),
    .BYTE_SWAP (BYTE_SWAP)
  ) u_align (
    .src  (src),
    .dre  (r_dre),
    .sext (r_sext),
    .data (ld_data),
    .err  (ld_err)
  );

  // Drive the write ports. An illegal load suppresses the register write,
  // and the data outputs are zero whenever their enable is low.
  always_comb begin
    lderr          = r_mreg & ld_err;
    wreg           = r_wreg & ~lderr;
    bus.wb_wa_o    = r_wa;
    bus.wb_wreg_o  = wreg;
    bus.wb_wd_o    = '0;
    if (wreg) bus.wb_wd_o = r_mreg ? ld_data : r_dreg;
    bus.wb_lderr_o = lderr;
    bus.wb_whilo_o = r_whilo;
    bus.wb_hilo_o  = r_whilo ? r_hilo : '0;
  end

endmodule
